multdiv_stage: RTL and testbench

MULTDIV_STAGE -- requirements
Module: multdiv_stage

---
 rtl/multdiv_stage.sv | 153 +++++++++++++++
 tb/tb_multdiv_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_stage.sv
// Multi-cycle signed multiply/divide unit in the execute stage.
// A mul or div takes 32 iterations and holds the pipeline with stall while
// it runs. The DONE cycle presents the result with a one-cycle strobe.
// The pipeline advances in that cycle so the result reaches the X/M latch.
module multdiv_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] executeIR,
    input  logic        op_valid,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [31:0] resultIR,
    output logic        exception,
    output logic [31:0] rstatus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  count;

    // Working registers: multiplier path
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    // Working registers: restoring divider path (magnitudes)
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic        negQ;
    logic        divZero;
    logic        opDiv;
    logic [31:0] irHold;

    logic        isMulDiv;
    logic        accept;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [63:0] mulTerm;
    logic [63:0] prodNext;
    logic [32:0] remShift;
    logic [32:0] trial;
    logic [31:0] remNext;
    logic [31:0] quotNext;
    logic [31:0] finalRes;
    logic        finalExc;

    // Decode: opcode 00000 with ALU op 00110 (mul) or 00111 (div)
    assign isMulDiv = op_valid && (executeIR[31:27] == 5'b00000) &&
                      ((executeIR[6:2] == 5'b00110) || (executeIR[6:2] == 5'b00111));
    // Reset gating keeps stall low while reset is held even if a start is presented
    assign accept   = reset && (state == IDLE) && isMulDiv && !flush;

    assign stall        = accept || (state == BUSY);
    assign result_valid = (state == DONE) && !flush;
    assign rstatus      = (result_valid && exception) ? (opDiv ? 32'd5 : 32'd4) : 32'd0;

    assign magA = operandA[31] ? -operandA : operandA;
    assign magB = operandB[31] ? -operandB : operandB;

    // One iteration of each datapath plus final sign/exception resolution
    always_comb begin
        mulTerm  = mplier[0] ? mcand : 64'd0;
        // The multiplier's bit 31 carries weight -2^31 in two's complement
        prodNext = (count == 5'd31) ? (prod - mulTerm) : (prod + mulTerm);

        remShift = {rem, quot[31]};
        trial    = remShift - {1'b0, divisor};
        if (!trial[32]) begin
            remNext  = trial[31:0];
            quotNext = {quot[30:0], 1'b1};
        end else begin
            remNext  = remShift[31:0];
            quotNext = {quot[30:0], 1'b0};
        end

        if (opDiv) begin
            if (divZero) begin
                finalRes = 32'd0;
                finalExc = 1'b1;
            end else begin
                finalRes = negQ ? -quotNext : quotNext;
                // A positive quotient of magnitude 2^31 only arises from 0x80000000 / -1
                finalExc = !negQ && quotNext[31];
            end
        end else begin
            finalRes = prodNext[31:0];
            finalExc = (prodNext[63:32] != {32{prodNext[31]}});
        end
    end

    // Datapath: capture operands at start, iterate while BUSY
    always_ff @(posedge clock) begin
        if (accept) begin
            opDiv   <= executeIR[2];
            irHold  <= executeIR;
            mcand   <= {{32{operandA[31]}}, operandA};
            mplier  <= operandB;
            prod    <= 64'd0;
            rem     <= 32'd0;
            quot    <= magA;
            divisor <= magB;
            negQ    <= operandA[31] ^ operandB[31];
            divZero <= (operandB == 32'd0);
        end else if (state == BUSY) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prodNext;
            rem    <= remNext;
            quot   <= quotNext;
        end
    end

    // Control FSM and registered result outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 5'd0;
            result    <= 32'd0;
            resultIR  <= 32'd0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                        count <= 5'd0;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state     <= DONE;
                            result    <= finalRes;
                            exception <= finalExc;
                            resultIR  <= irHold;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_stage.sv
// Bench for multdiv_stage: directed cases, randomized ops against an
// arithmetic reference model, flush, reset and back-to-back scenarios.
module tb_multdiv_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] executeIR = 32'd0;
    logic        op_valid = 1'b0;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] resultIR;
    logic        exception;
    logic [31:0] rstatus;

    int total = 0;
    int bad   = 0;

    multdiv_stage dut (
        .clock(clock), .reset(reset), .executeIR(executeIR), .op_valid(op_valid),
        .operandA(operandA), .operandB(operandB), .flush(flush), .stall(stall),
        .result(result), .result_valid(result_valid), .resultIR(resultIR),
        .exception(exception), .rstatus(rstatus)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mkIR(input bit isDiv);
        logic [19:0] mid;
        logic [1:0]  lo;
        mid = 20'($urandom);
        lo  = 2'($urandom);
        return {5'b00000, mid, (isDiv ? 5'b00111 : 5'b00110), lo};
    endfunction

    // Reference: plain 64-bit signed arithmetic, truncating division
    function automatic void model(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!isDiv) begin
            v = sa * sb;
            r = v[31:0];
            e = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            v = sa / sb;
            r = v[31:0];
            e = (v > 64'sd2147483647);
        end
    endfunction

    // Issues one op and follows it for up to 45 cycles, scrambling operands
    // after the start cycle. Cycle 1 is the start cycle.
    task automatic issue(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                         input int flushCycle, output logic [31:0] ir, output bit got,
                         output int lat, output int stCnt, output logic [31:0] res,
                         output logic [31:0] rir, output logic exc, output logic [31:0] rst);
        int c;
        got = 1'b0; lat = 0; stCnt = 0; res = 32'd0; rir = 32'd0; exc = 1'b0; rst = 32'd0;
        ir = mkIR(isDiv);
        @(negedge clock);
        executeIR = ir; operandA = a; operandB = b; op_valid = 1'b1;
        flush = (flushCycle == 1);
        #1;
        if (stall) stCnt++;
        c = 1;
        while (!got && c < 45) begin
            @(negedge clock);
            c++;
            op_valid = 1'b0;
            executeIR = $urandom; operandA = $urandom; operandB = $urandom;
            flush = (c == flushCycle);
            #1;
            if (result_valid) begin
                got = 1'b1; lat = c; res = result; rir = resultIR; exc = exception; rst = rstatus;
            end
            if (stall) stCnt++;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset;
        executeIR = mkIR(1'b0); op_valid = 1'b1; operandA = 32'd9; operandB = 32'd9;
        repeat (3) @(negedge clock);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if (resultIR !== 32'd0) begin bad++; $display("FAIL reset_resultIR got=%h want=0", resultIR); end
        total++; if (exception !== 1'b0) begin bad++; $display("FAIL reset_exception got=%b want=0", exception); end
        total++; if (rstatus !== 32'd0) begin bad++; $display("FAIL reset_rstatus got=%h want=0", rstatus); end
        op_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic test_directed;
        bit          dv  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] da  [5] = '{32'd7, 32'h00010000, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] db  [5] = '{32'hFFFFFFFA, 32'h00010000, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [31:0] er  [5] = '{32'hFFFFFFD6, 32'd0, 32'hFFFFFFFD, 32'd0, 32'h80000000};
        logic        ee  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] es  [5] = '{32'd0, 32'd4, 32'd0, 32'd5, 32'd5};
        logic [31:0] ir, res, rir, rst;
        logic        exc;
        bit          got;
        int          lat, stCnt;
        for (int i = 0; i < 5; i++) begin
            issue(dv[i], da[i], db[i], 0, ir, got, lat, stCnt, res, rir, exc, rst);
            total++; if (lat !== 34) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=34", i, lat); end
            total++; if (stCnt !== 33) begin bad++; $display("FAIL dir_stall_cycles[%0d] got=%0d want=33", i, stCnt); end
            total++; if (res !== er[i]) begin bad++; $display("FAIL dir_result[%0d] got=%h want=%h", i, res, er[i]); end
            total++; if (exc !== ee[i]) begin bad++; $display("FAIL dir_exception[%0d] got=%b want=%b", i, exc, ee[i]); end
            total++; if (rst !== es[i]) begin bad++; $display("FAIL dir_rstatus[%0d] got=%h want=%h", i, rst, es[i]); end
            total++; if (rir !== ir) begin bad++; $display("FAIL dir_resultIR[%0d] got=%h want=%h", i, rir, ir); end
            @(negedge clock);
            #1;
            total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL dir_valid_after[%0d] got=%b want=0", i, result_valid); end
            total++; if (result !== er[i]) begin bad++; $display("FAIL dir_hold_result[%0d] got=%h want=%h", i, result, er[i]); end
            total++; if (rstatus !== 32'd0) begin bad++; $display("FAIL dir_rstatus_after[%0d] got=%h want=0", i, rstatus); end
        end
    endtask

    task automatic test_random;
        logic [31:0] edges [6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};
        logic [31:0] a, b, ir, res, rir, rst, er;
        logic        exc, ee;
        bit          got, isDiv;
        int          lat, stCnt;
        for (int i = 0; i < 24; i++) begin
            isDiv = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 30);
            model(isDiv, a, b, er, ee);
            issue(isDiv, a, b, 0, ir, got, lat, stCnt, res, rir, exc, rst);
            total++; if (lat !== 34) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d want=34", i, lat); end
            total++; if (res !== er) begin bad++; $display("FAIL rnd_result[%0d] div=%0d a=%h b=%h got=%h want=%h", i, isDiv, a, b, res, er); end
            total++; if (exc !== ee) begin bad++; $display("FAIL rnd_exception[%0d] div=%0d a=%h b=%h got=%b want=%b", i, isDiv, a, b, exc, ee); end
            total++; if (rst !== (ee ? (isDiv ? 32'd5 : 32'd4) : 32'd0)) begin bad++; $display("FAIL rnd_rstatus[%0d] got=%h", i, rst); end
            total++; if (rir !== ir) begin bad++; $display("FAIL rnd_resultIR[%0d] got=%h want=%h", i, rir, ir); end
        end
    endtask

    task automatic test_flush;
        logic [31:0] ir, res, rir, rst, er, a, b;
        logic        exc, ee;
        bit          got;
        int          lat, stCnt;
        // Flush at BUSY cycle 10 (overall cycle 11)
        issue(1'b0, 32'd12345, 32'd678, 11, ir, got, lat, stCnt, res, rir, exc, rst);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL flush_busy_valid got=%b want=0", got); end
        total++; if (stCnt !== 11) begin bad++; $display("FAIL flush_busy_stall_cycles got=%0d want=11", stCnt); end
        a = $urandom; b = $urandom;
        model(1'b0, a, b, er, ee);
        issue(1'b0, a, b, 0, ir, got, lat, stCnt, res, rir, exc, rst);
        total++; if (lat !== 34) begin bad++; $display("FAIL flush_next_latency got=%0d want=34", lat); end
        total++; if (res !== er) begin bad++; $display("FAIL flush_next_result got=%h want=%h", res, er); end
        total++; if (exc !== ee) begin bad++; $display("FAIL flush_next_exception got=%b want=%b", exc, ee); end
        // Flush during DONE suppresses the strobe
        issue(1'b1, 32'd1000, 32'd7, 34, ir, got, lat, stCnt, res, rir, exc, rst);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b want=0", got); end
        total++; if (stCnt !== 33) begin bad++; $display("FAIL flush_done_stall_cycles got=%0d want=33", stCnt); end
        // Flush in IDLE blocks the start
        issue(1'b0, 32'd5, 32'd5, 1, ir, got, lat, stCnt, res, rir, exc, rst);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL flush_idle_valid got=%b want=0", got); end
        total++; if (stCnt !== 0) begin bad++; $display("FAIL flush_idle_stall_cycles got=%0d want=0", stCnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ir, res, rir, rst, er, a, b;
        logic        exc, ee;
        bit          got, isDiv;
        int          lat, stCnt;
        for (int i = 0; i < 3; i++) begin
            isDiv = 1'(i);
            a = $urandom; b = $urandom >> 4;
            model(isDiv, a, b, er, ee);
            issue(isDiv, a, b, 0, ir, got, lat, stCnt, res, rir, exc, rst);
            total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=34", i, lat); end
            total++; if (res !== er) begin bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, res, er); end
            // Present a start during DONE: it must be ignored
            executeIR = mkIR(1'b0); op_valid = 1'b1; operandA = 32'd3; operandB = 32'd3;
            #1;
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_done_stall[%0d] got=%b want=0", i, stall); end
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] ir, res, rir, rst;
        logic        exc;
        bit          got;
        int          lat, stCnt;
        @(negedge clock);
        executeIR = mkIR(1'b0); operandA = 32'h00012345; operandB = 32'h00000777; op_valid = 1'b1;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b want=0", stall); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", result_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rmid_result got=%h want=0", result); end
        total++; if (resultIR !== 32'd0) begin bad++; $display("FAIL rmid_resultIR got=%h want=0", resultIR); end
        total++; if (exception !== 1'b0) begin bad++; $display("FAIL rmid_exception got=%b want=0", exception); end
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        issue(1'b0, 32'd3, 32'd5, 0, ir, got, lat, stCnt, res, rir, exc, rst);
        total++; if (lat !== 34) begin bad++; $display("FAIL rmid_after_latency got=%0d want=34", lat); end
        total++; if (res !== 32'd15) begin bad++; $display("FAIL rmid_after_result got=%h want=0000000f", res); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL rmid_after_exception got=%b want=0", exc); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
